// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
package uart_pkg;

  localparam int unsigned UART_BYTE_W       = 8;
  localparam int unsigned TIMEOUT_BITS_DFLT = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the TX FIFO write port that the arbiter sits between.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned REQUESTERS = 4
);

  logic [REQUESTERS-1:0]             req_valid;
  logic [UART_BYTE_W*REQUESTERS-1:0] req_data;
  logic [REQUESTERS-1:0]             req_last;
  logic [REQUESTERS-1:0]             req_ready;
  logic [UART_BYTE_W-1:0]            fifo_data;
  logic                              fifo_we;
  logic                              fifo_full;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_data, fifo_we
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_data, fifo_we
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last, wrapping modulo N.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(last) + k) % N);
      if (!any && req[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locking round-robin arbiter sharing one UART TX FIFO write port among requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned TIMEOUT_BITS = TIMEOUT_BITS_DFLT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [TIMEOUT_BITS-1:0] idleTimeout,
  uart_tx_arbiter_if.slave        bus,
  output logic [REQUESTERS-1:0]   grant,
  output logic                    grantValid,
  output logic                    timeoutEvent
);

  localparam int unsigned IDX_W = $clog2(REQUESTERS);

  arb_state_t              state;
  logic [IDX_W-1:0]        owner;
  logic [IDX_W-1:0]        last_grant;
  logic [TIMEOUT_BITS-1:0] idle_cnt;

  logic [REQUESTERS-1:0]   pick;
  logic                    pick_any;
  logic [IDX_W-1:0]        pick_idx;
  logic                    own_valid;
  logic                    own_last;
  logic                    active;
  logic                    xfer;
  logic                    timeout_hit;
  logic [TIMEOUT_BITS-1:0] cnt_inc;

  rr_pick #(.N(REQUESTERS)) u_pick (
    .req  (bus.req_valid & {REQUESTERS{enable}}),
    .last (last_grant),
    .pick (pick),
    .any  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // Owner's byte goes straight through to the FIFO; no buffering in the arbiter.
  assign own_valid   = bus.req_valid[owner];
  assign own_last    = bus.req_last[owner];
  assign active      = (state == LOCKED) && enable && !rst;
  assign xfer        = active && own_valid && !bus.fifo_full;
  assign cnt_inc     = (idle_cnt == '1) ? idle_cnt : idle_cnt + TIMEOUT_BITS'(1);
  assign timeout_hit = (idleTimeout != '0) && (cnt_inc >= idleTimeout);

  assign bus.fifo_we   = xfer;
  assign bus.fifo_data = (state == LOCKED) ? bus.req_data[UART_BYTE_W*owner +: UART_BYTE_W]
                                           : '0;

  always_comb begin
    bus.req_ready = '0;
    if (active && !bus.fifo_full) bus.req_ready[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      grantValid   <= 1'b0;
      timeoutEvent <= 1'b0;
      idle_cnt     <= '0;
      owner        <= '0;
      last_grant   <= IDX_W'(REQUESTERS - 1);
    end else begin
      timeoutEvent <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state      <= LOCKED;
            grant      <= pick;
            grantValid <= 1'b1;
            owner      <= pick_idx;
            idle_cnt   <= '0;
          end
        end
        LOCKED: begin
          // Transfers take precedence over timeout; only an idle owner can time out.
          if (!enable || (xfer && own_last) || (!own_valid && timeout_hit)) begin
            state        <= IDLE;
            grant        <= '0;
            grantValid   <= 1'b0;
            last_grant   <= owner;
            idle_cnt     <= '0;
            timeoutEvent <= enable && !own_valid && timeout_hit;
          end else if (xfer) begin
            idle_cnt <= '0;
          end else if (!own_valid) begin
            idle_cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected FIFO bytes queued at stimulus time, popped on writes.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned TB = 16;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } src_byte_t;

  typedef struct packed {
    logic [1:0] who;
    logic [7:0] data;
  } exp_byte_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [TB-1:0] idle_timeout;
  logic [NR-1:0] grant;
  logic          grant_valid;
  logic          timeout_event;

  src_byte_t src_q[NR][$];
  exp_byte_t exp_q[$];
  int        grant_log[$];
  int        wcycle[$];
  int        cyc;
  int        te_count;
  int        te_mark;
  int        n;
  int        checks;
  int        failures;
  logic      gv_prev;

  uart_tx_arbiter_if #(.REQUESTERS(NR)) bus ();

  uart_tx_arbiter #(.REQUESTERS(NR), .TIMEOUT_BITS(TB)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .idleTimeout  (idle_timeout),
    .bus          (bus),
    .grant        (grant),
    .grantValid   (grant_valid),
    .timeoutEvent (timeout_event)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = src_q[i][0].data;
        bus.req_last[i]        = src_q[i][0].last;
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic send(input int who, input logic [7:0] d, input logic l);
    src_byte_t b;
    b.last = l;
    b.data = d;
    src_q[who].push_back(b);
  endtask

  task automatic expect_byte(input int who, input logic [7:0] d);
    exp_byte_t e;
    e.who  = 2'(who);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock: score FIFO writes at negedge, retire accepted bytes after the edge.
  task automatic step();
    logic [NR-1:0] acc;
    exp_byte_t     e;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    if (timeout_event) te_count++;
    if (bus.fifo_we || acc != '0) begin
      check_eq("ready_matches_we", 32'(acc != '0), 32'(bus.fifo_we));
    end
    if (bus.fifo_we) begin
      wcycle.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_eq("spurious_write", 32'(bus.fifo_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("fifo_data", 32'(bus.fifo_data), 32'(e.data));
        check_eq("writer_grant", 32'(grant), 32'(1) << e.who);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) if (acc[i]) void'(src_q[i].pop_front());
    if (grant_valid && !gv_prev) grant_log.push_back(onehot_idx(grant));
    gv_prev = grant_valid;
    drive();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check_eq("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    te_count      = 0;
    gv_prev       = 1'b0;
    rst           = 1'b1;
    enable        = 1'b1;
    idle_timeout  = '0;
    bus.fifo_full = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_grant_valid", 32'(grant_valid), 32'd0);
    check_eq("rst_timeout_event", 32'(timeout_event), 32'd0);
    check_eq("rst_fifo_we", 32'(bus.fifo_we), 32'd0);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;

    // Two 3-byte messages from requesters 0 and 2.
    send(0, 8'h10, 1'b0); send(0, 8'h11, 1'b0); send(0, 8'h12, 1'b1);
    send(2, 8'h30, 1'b0); send(2, 8'h31, 1'b0); send(2, 8'h32, 1'b1);
    expect_byte(0, 8'h10); expect_byte(0, 8'h11); expect_byte(0, 8'h12);
    expect_byte(2, 8'h30); expect_byte(2, 8'h31); expect_byte(2, 8'h32);
    wcycle.delete();
    drive();
    step();
    check_eq("t1_first_grant", 32'(grant), 32'b0001);
    check_eq("t1_grant_valid", 32'(grant_valid), 32'd1);
    repeat (3) step();
    check_eq("t1_idle_gap", 32'(grant), 32'd0);
    step();
    check_eq("t1_second_grant", 32'(grant), 32'b0100);
    drain(20);
    check_eq("t1_log_n", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check_eq("t1_log0", 32'(grant_log[0]), 32'd0);
      check_eq("t1_log1", 32'(grant_log[1]), 32'd2);
    end
    check_eq("t1_writes", 32'(wcycle.size()), 32'd6);
    if (wcycle.size() == 6) begin
      check_eq("t1_gap01", 32'(wcycle[1] - wcycle[0]), 32'd1);
      check_eq("t1_gap23", 32'(wcycle[3] - wcycle[2]), 32'd2);
      check_eq("t1_gap45", 32'(wcycle[5] - wcycle[4]), 32'd1);
    end

    // Requester 3 must not cut into requester 1's open message.
    send(1, 8'h41, 1'b0);
    expect_byte(1, 8'h41);
    drive();
    step();
    check_eq("t2_grant1", 32'(grant), 32'b0010);
    step();
    send(3, 8'h55, 1'b1);
    drive();
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("t2_ready3_held", 32'(bus.req_ready[3]), 32'd0);
      step();
    end
    check_eq("t2_still_grant1", 32'(grant), 32'b0010);
    send(1, 8'h0A, 1'b1);
    expect_byte(1, 8'h0A);
    expect_byte(3, 8'h55);
    drive();
    step();
    check_eq("t2_release", 32'(grant), 32'd0);
    step();
    check_eq("t2_grant3", 32'(grant), 32'b1000);
    drain(10);

    // Idle timeout of 5 cycles after the owner drops valid.
    idle_timeout = 16'd5;
    send(2, 8'h77, 1'b0);
    expect_byte(2, 8'h77);
    drive();
    step();
    check_eq("t3_grant2", 32'(grant), 32'b0100);
    step();
    n = 0;
    while (grant_valid && n < 20) begin
      step();
      n++;
    end
    check_eq("t3_release_delay", 32'(n), 32'd5);
    check_eq("t3_event_high", 32'(timeout_event), 32'd1);
    step();
    check_eq("t3_event_pulse", 32'(timeout_event), 32'd0);
    check_eq("t3_event_count", 32'(te_count), 32'd1);
    idle_timeout = 16'd0;
    send(2, 8'h78, 1'b0);
    expect_byte(2, 8'h78);
    drive();
    step();
    step();
    te_mark = te_count;
    repeat (1000) step();
    check_eq("t3_never_release", 32'(grant_valid), 32'd1);
    check_eq("t3_no_event", 32'(te_count), 32'(te_mark));
    send(2, 8'h79, 1'b1);
    expect_byte(2, 8'h79);
    drive();
    drain(5);
    step();

    // Backpressure: fifo_full must neither let bytes through nor cause a timeout.
    idle_timeout  = 16'd3;
    bus.fifo_full = 1'b1;
    te_mark       = te_count;
    send(3, 8'h90, 1'b1);
    expect_byte(3, 8'h90);
    drive();
    step();
    check_eq("t4_grant3", 32'(grant), 32'b1000);
    for (int i = 0; i < 20; i++) begin
      #1;
      check_eq("t4_we_blocked", 32'(bus.fifo_we), 32'd0);
      check_eq("t4_ready_blocked", 32'(bus.req_ready), 32'd0);
      step();
    end
    check_eq("t4_still_locked", 32'(grant_valid), 32'd1);
    check_eq("t4_no_timeout", 32'(te_count), 32'(te_mark));
    bus.fifo_full = 1'b0;
    #1;
    check_eq("t4_we_same_cycle", 32'(bus.fifo_we), 32'd1);
    check_eq("t4_data", 32'(bus.fifo_data), 32'h90);
    drain(5);
    step();

    // All four requesters with back-to-back single-byte messages.
    idle_timeout = 16'd0;
    grant_log.delete();
    wcycle.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) begin
        send(i, 8'(8'hA0 + 8'(16 * r) + 8'(i)), 1'b1);
        expect_byte(i, 8'(8'hA0 + 8'(16 * r) + 8'(i)));
      end
    end
    drive();
    drain(40);
    check_eq("t5_log_n", 32'(grant_log.size()), 32'd8);
    if (grant_log.size() == 8) begin
      for (int i = 0; i < 6; i++) check_eq("t5_order", 32'(grant_log[i]), 32'(i % 4));
    end
    if (wcycle.size() == 8) begin
      for (int i = 0; i < 7; i++) check_eq("t5_spacing", 32'(wcycle[i+1] - wcycle[i]), 32'd2);
    end else begin
      check_eq("t5_writes", 32'(wcycle.size()), 32'd8);
    end
    step();

    // Disable mid-message.
    te_mark = te_count;
    send(1, 8'hC1, 1'b0);
    send(1, 8'hC2, 1'b0);
    expect_byte(1, 8'hC1);
    drive();
    step();
    check_eq("t6_grant1", 32'(grant), 32'b0010);
    step();
    enable = 1'b0;
    #1;
    check_eq("t6_we_off", 32'(bus.fifo_we), 32'd0);
    check_eq("t6_ready_off", 32'(bus.req_ready), 32'd0);
    step();
    check_eq("t6_released", 32'(grant_valid), 32'd0);
    check_eq("t6_no_event", 32'(timeout_event), 32'd0);
    step();
    check_eq("t6_no_regrant", 32'(grant_valid), 32'd0);
    check_eq("t6_no_event_count", 32'(te_count), 32'(te_mark));
    src_q[1].delete();
    enable = 1'b1;
    drive();

    // Reset while locked; priority restarts at requester 0.
    send(2, 8'hD1, 1'b0);
    expect_byte(2, 8'hD1);
    drive();
    step();
    check_eq("t6_grant2", 32'(grant), 32'b0100);
    step();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) send(i, 8'(8'hE0 + 8'(i)), 1'b1);
    drive();
    #1;
    check_eq("t6_rst_we", 32'(bus.fifo_we), 32'd0);
    check_eq("t6_rst_ready", 32'(bus.req_ready), 32'd0);
    step();
    check_eq("t6_rst_grant", 32'(grant), 32'd0);
    check_eq("t6_rst_gv", 32'(grant_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) expect_byte(i, 8'(8'hE0 + 8'(i)));
    step();
    check_eq("t6_post_rst_pick", 32'(grant), 32'b0001);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
